// File: rtl/mod3_serial_tx.sv
// mod3_serial_tx: MSB-first serializer; with MOD3_TX_CHECK_EN defined it appends
// a 2-bit check field so each frame is divisible by 3, otherwise frames are WIDTH bits.
module mod3_serial_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             tx_first,
  output logic             tx_last
);

  localparam int CW = $clog2(WIDTH);

`ifdef MOD3_TX_CHECK_EN
  typedef enum logic [1:0] {IDLE, DATA, CHK1, CHK0} state_e;
`else
  typedef enum logic {IDLE, DATA} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bit_q, bit_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             accept;

`ifdef MOD3_TX_CHECK_EN
  logic [1:0] res_q, res_d;
  logic [1:0] chk;

  // r' = (2r + b) mod 3
  function automatic logic [1:0] res_step(input logic [1:0] r, input logic b);
    unique case (r)
      2'd0:    res_step = {1'b0, b};
      2'd1:    res_step = b ? 2'd0 : 2'd2;
      default: res_step = b ? 2'd2 : 2'd1;
    endcase
  endfunction

  assign chk = (res_q == 2'd1) ? 2'b10 :
               (res_q == 2'd2) ? 2'b01 : 2'b00;

  assign in_ready = (state_q == IDLE) || (state_q == CHK0);
`else
  assign in_ready = (state_q == IDLE) ||
                    ((state_q == DATA) && (cnt_q == '0));
`endif

  assign accept = in_valid && in_ready;

  // Output regs hold the bit on the wire; cnt_q counts data bits still to come.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    bit_d   = 1'b0;
    valid_d = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
`ifdef MOD3_TX_CHECK_EN
    res_d   = res_q;
`endif
    if (accept) begin
      state_d = DATA;
      sreg_d  = {in_data[WIDTH-2:0], 1'b0};
      cnt_d   = CW'(WIDTH - 1);
      bit_d   = in_data[WIDTH-1];
      valid_d = 1'b1;
      first_d = 1'b1;
`ifdef MOD3_TX_CHECK_EN
      res_d   = {1'b0, in_data[WIDTH-1]};
`endif
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        DATA: begin
          if (cnt_q != '0) begin
            sreg_d  = {sreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - CW'(1);
            bit_d   = sreg_q[WIDTH-1];
            valid_d = 1'b1;
`ifdef MOD3_TX_CHECK_EN
            res_d   = res_step(res_q, sreg_q[WIDTH-1]);
`else
            last_d  = (cnt_q == CW'(1));
`endif
          end else begin
`ifdef MOD3_TX_CHECK_EN
            state_d = CHK1;
            bit_d   = chk[1];
            valid_d = 1'b1;
`else
            state_d = IDLE;
`endif
          end
        end
`ifdef MOD3_TX_CHECK_EN
        CHK1: begin
          state_d = CHK0;
          bit_d   = chk[0];
          valid_d = 1'b1;
          last_d  = 1'b1;
        end
        CHK0: state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef MOD3_TX_CHECK_EN
      res_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
`ifdef MOD3_TX_CHECK_EN
      res_q   <= res_d;
`endif
    end
  end

  assign tx_bit   = bit_q;
  assign tx_valid = valid_q;
  assign tx_first = first_q;
  assign tx_last  = last_q;

endmodule

// File: doc/mod3_serial_tx.md
# mod3_serial_tx

Serial transmitter for the divisible-by-3 bit-stream protocol. It accepts a parallel WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock. It then appends a 2-bit check field so that the whole frame, read as a binary number, is divisible by 3. It is the sending end of the link whose receiver tracks the running residue and flags remainder zero at the end of a frame.

## Interface
- WIDTH, 8: data word width in bits, minimum 2.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  WIDTH  word to transmit, MSB sent first.
- in_ready  output  1  transmitter can accept a word this cycle.
- tx_bit  output  1  current serial bit.
- tx_valid  output  1  tx_bit is a frame bit.
- tx_first  output  1  high with the first bit of a frame.
- tx_last  output  1  high with the last bit of a frame.

## Operation
- Clocking and reset:
  - Single clock, `clk`.
  - `reset_n` low asynchronously forces state IDLE and clears the shift register, bit counter and residue.
  - Outputs during reset: `tx_bit`=0, `tx_valid`=0, `tx_first`=0, `tx_last`=0, `in_ready`=1.
- Handshake:
  - A word is accepted on a rising edge where `in_valid && in_ready`.
  - `in_data` is captured into the shift register and is ignored at all other times.
- State machine, states IDLE, DATA, CHK1, CHK0:
  - IDLE: `in_ready`=1. On accept, go to DATA with the bit count set to WIDTH-1 and the residue set to 0.
  - DATA: drive `tx_bit` = shift register MSB and shift left each cycle.
    - Residue update per bit: r' = (2r + bit) mod 3, with r in {0,1,2}.
    - After WIDTH bits, go to CHK1.
  - CHK1 and CHK0 send the check field c = (3 − r) mod 3, computed from the residue over all WIDTH data bits.
    - Encoding: r=0 gives c=00, r=1 gives c=10, r=2 gives c=01.
    - CHK1 sends c[1]; CHK0 sends c[0].
  - CHK0: `in_ready`=1.
    - On accept, go straight to DATA (back-to-back frames, no gap).
    - Otherwise go to IDLE.
- Framing flags:
  - `tx_valid` is high in DATA, CHK1 and CHK0.
  - `tx_first` is high on the first DATA cycle only.
  - `tx_last` is high in CHK0 only.
- Frame property: for every frame, the (WIDTH+2)-bit value is ≡ 0 mod 3.
- `in_ready` is low in DATA and CHK1. `in_valid` during those states is not accepted and causes no error.

## Timing
- All serial outputs are registered.
- The first frame bit appears on the cycle after the accepting edge.
- Frame length is WIDTH+2 cycles. `tx_valid` is continuous across back-to-back frames.
- Sustained throughput is one word per WIDTH+2 cycles. An accept in IDLE adds one idle cycle between frames.
- `in_ready` is combinational from state only, never from `in_valid`.
- Reset asserted mid-frame aborts the frame immediately, with no check bits emitted.
  - The first accept after release starts a fresh frame with residue 0.

## Configuration
- `MOD3_TX_CHECK_EN` defined:
  - Check field appended as above.
  - Frame = WIDTH+2 bits; states CHK1 and CHK0 present.
- `MOD3_TX_CHECK_EN` undefined:
  - Plain MSB-first serializer; residue logic and CHK states removed.
  - Frame = WIDTH bits.
  - `tx_last` and `in_ready` are high on the final DATA bit, and back-to-back acceptance happens there.

## Test plan
- Reset: hold `reset_n` low for 3 cycles, then release → `in_ready`=1, `tx_valid`=0, `tx_bit`=0, `tx_first`=0, `tx_last`=0.
- Basic frames, WIDTH=8:
  - in_data=0x05 → stream 0000_0101_01 (decimal 21); `tx_first` on bit 1, `tx_last` on bit 10.
  - 0x07 → 0000_0111_10 (decimal 30).
  - 0x06 → 0000_0110_00.
  - 0xFF → 1111_1111_00.
- Back-to-back: hold `in_valid`=1 with 0x01 then 0x02 → `tx_valid` high for 20 consecutive cycles.
  - Stream 0000_0001_10 then 0000_0010_01.
  - `tx_first` at cycles 1 and 11; `in_ready` high only in IDLE and on cycles 10 and 20.
- Stall: `in_valid` pulsed during DATA → word not accepted, frame unaffected, `in_ready` stays 0 until CHK0.
- Reset mid-frame: drive `reset_n` low on data bit 4 of 0xA5 → `tx_valid` drops asynchronously.
  - After release, sending 0x03 gives 0000_0011_00 (residue restarted from 0).
- Self-check: random words over 1000 frames feed a reference mod-3 receiver model → remainder 0 at every `tx_last`.
  - Repeat with `MOD3_TX_CHECK_EN` undefined: each frame is 8 cycles, equals in_data, and `tx_last` is on bit 8.
